// File: rtl/uart_tx_fifo_if.sv
// Purpose: bus/transmitter bundle for uart_tx_fifo (write side, launch handshake, status).
// Latency: n/a (wires only).
// Backpressure: none here; the FIFO flags full/overflow and waits on tx_rdy.
// Ports: wr_en/wr_data/ovf_clr/tx_rdy come from the bus side and the transmitter;
//        din/din_rdy/full/empty/count/overflow are driven by the FIFO.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  ovf_clr;
    logic                  tx_rdy;
    logic [7:0]            din;
    logic                  din_rdy;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;

    modport master (
        output wr_en, wr_data, ovf_clr, tx_rdy,
        input  din, din_rdy, full, empty, count, overflow
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr, tx_rdy,
        output din, din_rdy, full, empty, count, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose: circular byte FIFO feeding a UART transmitter, one launch pulse per byte.
// Latency: write at edge k into empty FIFO -> din_rdy/din after k+1, pop at k+2.
// Backpressure: writes while full are dropped (sticky overflow); launches wait for tx_rdy to cycle low->high.
// Ports: clk, rst (async active-low), bus (uart_tx_fifo_if.slave).
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input logic           clk,
    input logic           rst,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;

    state_t                state_q, state_d;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            din_q, din_d;
    logic                  din_rdy_q, din_rdy_d;

    logic full, empty, wr_ok, launch, pop;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    // full is the pre-edge value, so a write is dropped even if a pop lands on the same edge
    assign wr_ok = bus.wr_en && !full;

    // ---------------- launch FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- launch FSM: next state ----------------
    // WAIT_LOW confirms the transmitter latched the byte; WAIT_HIGH covers the
    // frame and its inter-frame gap before the next byte may be offered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!empty && bus.tx_rdy) state_d = ISSUE;
            ISSUE:     state_d = WAIT_LOW;
            WAIT_LOW:  if (!bus.tx_rdy) state_d = WAIT_HIGH;
            WAIT_HIGH: if (bus.tx_rdy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // ---------------- launch FSM: outputs ----------------
    always_comb begin
        launch    = (state_q == IDLE) && !empty && bus.tx_rdy;
        pop       = (state_q == ISSUE);
        din_rdy_d = launch;
        din_d     = launch ? mem_q[rd_ptr_q] : din_q;
    end

    // ---------------- pointers, count, overflow ----------------
    always_comb begin
        wr_ptr_d = wr_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({wr_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // a dropped write outranks a same-edge clear
        if (bus.wr_en && full) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            din_q     <= 8'h00;
            din_rdy_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            din_q     <= din_d;
            din_rdy_q <= din_rdy_d;
        end
    end

    // storage needs no reset; entries are only read after being written
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.din      = din_q;
    assign bus.din_rdy  = din_rdy_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
endmodule
